// File: rtl/exec_pkg.sv
// Shared definitions for the RV32I execute stage: ALU op codes, forward selects,
// and the EX/MEM pipeline register layout.
package exec_pkg;

    localparam int DATA_W_PKG = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_MUL = 3'b110;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic                    reg_write;
        logic                    mem_write;
        logic                    result_src;
        logic [4:0]              rd;
        logic [DATA_W_PKG-1:0]   alu_result;
        logic [DATA_W_PKG-1:0]   write_data;
        logic [DATA_W_PKG-1:0]   pc_plus4;
    } exmem_t;

    // The reserved select 11 falls back to the register value.
    function automatic logic [DATA_W_PKG-1:0] fwd_select(
        input logic [1:0]            sel,
        input logic [DATA_W_PKG-1:0] reg_val,
        input logic [DATA_W_PKG-1:0] wb_val,
        input logic [DATA_W_PKG-1:0] mem_val
    );
        logic [DATA_W_PKG-1:0] r;
        case (sel)
            FWD_WB:  r = wb_val;
            FWD_MEM: r = mem_val;
            default: r = reg_val;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/execute_cycle_alu.sv
// Combinational ALU for the execute stage.
// Optional multiplier on op 110 is built only when EXEC_MUL_EN is defined.
module alu
    import exec_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [2:0]        ALUControl,
    output logic [DATA_W-1:0] Result,
    output logic              Zero
);

`ifdef EXEC_MUL_EN
    logic [DATA_W-1:0] product;
    assign product = A * B;
`endif

    always_comb begin
        Result = '0;
        case (ALUControl)
            ALU_ADD: Result = A + B;
            ALU_SUB: Result = A - B;
            ALU_AND: Result = A & B;
            ALU_OR:  Result = A | B;
            ALU_SLT: Result = {{(DATA_W-1){1'b0}}, ($signed(A) < $signed(B))};
`ifdef EXEC_MUL_EN
            ALU_MUL: Result = product;
`endif
            default: Result = '0;
        endcase
    end

    assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// RV32I execute stage: operand forwarding, ALU, beq resolution and the EX/MEM register.
// Build with EXEC_MUL_EN defined to enable the single-cycle multiply on op 110.
module execute_cycle
    import exec_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteE,
    input  logic              ALUSrcE,
    input  logic              MemWriteE,
    input  logic              ResultSrcE,
    input  logic              BranchE,
    input  logic [2:0]        ALUControlE,
    input  logic [DATA_W-1:0] RD1_E,
    input  logic [DATA_W-1:0] RD2_E,
    input  logic [DATA_W-1:0] Imm_Ext_E,
    input  logic [4:0]        RD_E,
    input  logic [DATA_W-1:0] PCE,
    input  logic [DATA_W-1:0] PCPlus4E,
    input  logic [DATA_W-1:0] ResultW,
    input  logic [1:0]        ForwardA_E,
    input  logic [1:0]        ForwardB_E,
    input  logic              EnM,
    input  logic              ClrM,
    output logic              PCSrcE,
    output logic [DATA_W-1:0] PCTargetE,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic              ResultSrcM,
    output logic [4:0]        RD_M,
    output logic [DATA_W-1:0] ALU_ResultM,
    output logic [DATA_W-1:0] WriteDataM,
    output logic [DATA_W-1:0] PCPlus4M
);

    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] src_b;
    logic [DATA_W-1:0] alu_result;
    logic              zero;
    exmem_t            exmem_q;
    exmem_t            exmem_d;

    // Stage-M ALU result feeds back for back-to-back dependent instructions.
    assign src_a = fwd_select(ForwardA_E, RD1_E, ResultW, exmem_q.alu_result);
    assign fwd_b = fwd_select(ForwardB_E, RD2_E, ResultW, exmem_q.alu_result);
    assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;

    alu #(.DATA_W(DATA_W)) u_alu (
        .A          (src_a),
        .B          (src_b),
        .ALUControl (ALUControlE),
        .Result     (alu_result),
        .Zero       (zero)
    );

    assign PCSrcE    = BranchE & zero;
    assign PCTargetE = PCE + Imm_Ext_E;

    always_comb begin
        exmem_d            = '0;
        exmem_d.reg_write  = RegWriteE;
        exmem_d.mem_write  = MemWriteE;
        exmem_d.result_src = ResultSrcE;
        exmem_d.rd         = RD_E;
        exmem_d.alu_result = alu_result;
        exmem_d.write_data = fwd_b;
        exmem_d.pc_plus4   = PCPlus4E;
    end

    // Clear beats enable so the hazard unit can always force a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exmem_q <= '0;
        end else if (ClrM) begin
            exmem_q <= '0;
        end else if (EnM) begin
            exmem_q <= exmem_d;
        end
    end

    assign RegWriteM   = exmem_q.reg_write;
    assign MemWriteM   = exmem_q.mem_write;
    assign ResultSrcM  = exmem_q.result_src;
    assign RD_M        = exmem_q.rd;
    assign ALU_ResultM = exmem_q.alu_result;
    assign WriteDataM  = exmem_q.write_data;
    assign PCPlus4M    = exmem_q.pc_plus4;

endmodule

// File: tb/tb_execute_cycle.sv
// Directed table-driven bench for execute_cycle plus hand sequences for
// forwarding from M, hold, clear and asynchronous reset.
module tb_execute_cycle;

    logic        clk;
    logic        rst;
    logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E;
    logic [4:0]  RD_E;
    logic [31:0] PCE, PCPlus4E, ResultW;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic        EnM, ClrM;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] ALU_ResultM, WriteDataM, PCPlus4M;

    int total;
    int bad;

    typedef struct packed {
        logic [2:0]  op;
        logic        alusrc;
        logic        branch;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pce;
        logic [31:0] resw;
        logic [31:0] exp_res;
        logic [31:0] exp_wd;
        logic        exp_pcsrc;
    } vec_t;

    localparam int NVEC = 15;
    vec_t tbl [NVEC];

`ifdef EXEC_MUL_EN
    localparam logic [31:0] MUL_EXP = 32'd42;
`else
    localparam logic [31:0] MUL_EXP = 32'd0;
`endif

    execute_cycle dut (
        .clk         (clk),
        .rst         (rst),
        .RegWriteE   (RegWriteE),
        .ALUSrcE     (ALUSrcE),
        .MemWriteE   (MemWriteE),
        .ResultSrcE  (ResultSrcE),
        .BranchE     (BranchE),
        .ALUControlE (ALUControlE),
        .RD1_E       (RD1_E),
        .RD2_E       (RD2_E),
        .Imm_Ext_E   (Imm_Ext_E),
        .RD_E        (RD_E),
        .PCE         (PCE),
        .PCPlus4E    (PCPlus4E),
        .ResultW     (ResultW),
        .ForwardA_E  (ForwardA_E),
        .ForwardB_E  (ForwardB_E),
        .EnM         (EnM),
        .ClrM        (ClrM),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .RegWriteM   (RegWriteM),
        .MemWriteM   (MemWriteM),
        .ResultSrcM  (ResultSrcM),
        .RD_M        (RD_M),
        .ALU_ResultM (ALU_ResultM),
        .WriteDataM  (WriteDataM),
        .PCPlus4M    (PCPlus4M)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " RegWriteM"},   {31'd0, RegWriteM},  32'd0);
        checkOutput({tag, " MemWriteM"},   {31'd0, MemWriteM},  32'd0);
        checkOutput({tag, " ResultSrcM"},  {31'd0, ResultSrcM}, 32'd0);
        checkOutput({tag, " RD_M"},        {27'd0, RD_M},       32'd0);
        checkOutput({tag, " ALU_ResultM"}, ALU_ResultM,         32'd0);
        checkOutput({tag, " WriteDataM"},  WriteDataM,          32'd0);
        checkOutput({tag, " PCPlus4M"},    PCPlus4M,            32'd0);
    endtask

    // Side-band control fields are derived from the vector index.
    task automatic applyStimulus(input vec_t v, input int idx);
        ALUControlE = v.op;
        ALUSrcE     = v.alusrc;
        BranchE     = v.branch;
        ForwardA_E  = v.fa;
        ForwardB_E  = v.fb;
        RD1_E       = v.rd1;
        RD2_E       = v.rd2;
        Imm_Ext_E   = v.imm;
        PCE         = v.pce;
        ResultW     = v.resw;
        RegWriteE   = idx[0];
        MemWriteE   = idx[1];
        ResultSrcE  = idx[2];
        RD_E        = 5'(idx + 1);
        PCPlus4E    = 32'h1000 + 32'(idx * 4);
    endtask

    task automatic setAdd(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        ALUControlE = 3'b000;
        ALUSrcE     = 1'b0;
        BranchE     = 1'b0;
        ForwardA_E  = 2'b00;
        ForwardB_E  = 2'b00;
        RD1_E       = a;
        RD2_E       = b;
        RD_E        = rd;
        RegWriteE   = 1'b1;
        MemWriteE   = 1'b0;
        ResultSrcE  = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        //                op     src   br    fa     fb     rd1           rd2           imm           pce         resw          res           wd            pcsrc
        tbl[0]  = '{3'b000, 1'b0, 1'b0, 2'b00, 2'b00, 32'd5,        32'd7,        32'd0,        32'h100, 32'd0,        32'd12,       32'd7,        1'b0};
        tbl[1]  = '{3'b000, 1'b0, 1'b0, 2'b00, 2'b00, 32'd1,        32'd2,        32'd0,        32'h100, 32'd0,        32'd3,        32'd2,        1'b0};
        tbl[2]  = '{3'b001, 1'b0, 1'b1, 2'b00, 2'b00, 32'h55,       32'h55,       32'h20,       32'h100, 32'd0,        32'd0,        32'h55,       1'b1};
        tbl[3]  = '{3'b001, 1'b0, 1'b1, 2'b00, 2'b00, 32'd9,        32'd4,        32'h20,       32'h100, 32'd0,        32'd5,        32'd4,        1'b0};
        tbl[4]  = '{3'b101, 1'b0, 1'b0, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd1,        32'd0,        32'h100, 32'd0,        32'd1,        32'd1,        1'b0};
        tbl[5]  = '{3'b101, 1'b0, 1'b0, 2'b00, 2'b00, 32'd1,        32'hFFFFFFFF, 32'd0,        32'h100, 32'd0,        32'd0,        32'hFFFFFFFF, 1'b0};
        tbl[6]  = '{3'b000, 1'b0, 1'b1, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd1,        32'd8,        32'h200, 32'd0,        32'd0,        32'd1,        1'b1};
        tbl[7]  = '{3'b000, 1'b1, 1'b0, 2'b00, 2'b00, 32'd8,        32'hABCD,     32'hFFFFFFFC, 32'h100, 32'd0,        32'd4,        32'hABCD,     1'b0};
        tbl[8]  = '{3'b010, 1'b0, 1'b0, 2'b00, 2'b00, 32'hF0F0,     32'hFF00,     32'd0,        32'h100, 32'd0,        32'hF000,     32'hFF00,     1'b0};
        tbl[9]  = '{3'b011, 1'b0, 1'b0, 2'b00, 2'b00, 32'hF0F0,     32'h0F00,     32'd0,        32'h100, 32'd0,        32'hFFF0,     32'h0F00,     1'b0};
        tbl[10] = '{3'b100, 1'b0, 1'b1, 2'b00, 2'b00, 32'd3,        32'd4,        32'h40,       32'h300, 32'd0,        32'd0,        32'd4,        1'b1};
        tbl[11] = '{3'b111, 1'b0, 1'b0, 2'b00, 2'b00, 32'd3,        32'd4,        32'd0,        32'h100, 32'd0,        32'd0,        32'd4,        1'b0};
        tbl[12] = '{3'b110, 1'b0, 1'b0, 2'b00, 2'b00, 32'd6,        32'd7,        32'd0,        32'h100, 32'd0,        MUL_EXP,      32'd7,        1'b0};
        tbl[13] = '{3'b000, 1'b0, 1'b0, 2'b01, 2'b00, 32'hDEAD,     32'd5,        32'd0,        32'h100, 32'h20,       32'h25,       32'd5,        1'b0};
        tbl[14] = '{3'b000, 1'b0, 1'b0, 2'b11, 2'b11, 32'd3,        32'd4,        32'd0,        32'h100, 32'h99,       32'd7,        32'd4,        1'b0};

        // Reset held with busy E inputs: M stays zero, branch target still live.
        rst  = 1'b1;
        EnM  = 1'b1;
        ClrM = 1'b0;
        applyStimulus(tbl[7], 7);
        RegWriteE = 1'b1;
        MemWriteE = 1'b1;
        tick();
        tick();
        checkAllZero("reset");
        checkOutput("reset PCTargetE", PCTargetE, 32'h000000FC);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(tbl[i], i);
            #1;
            checkOutput($sformatf("vec%0d PCSrcE", i), {31'd0, PCSrcE}, {31'd0, tbl[i].exp_pcsrc});
            checkOutput($sformatf("vec%0d PCTargetE", i), PCTargetE, tbl[i].pce + tbl[i].imm);
            tick();
            checkOutput($sformatf("vec%0d ALU_ResultM", i), ALU_ResultM, tbl[i].exp_res);
            checkOutput($sformatf("vec%0d WriteDataM", i), WriteDataM, tbl[i].exp_wd);
            checkOutput($sformatf("vec%0d RegWriteM", i), {31'd0, RegWriteM}, {31'd0, i[0]});
            checkOutput($sformatf("vec%0d MemWriteM", i), {31'd0, MemWriteM}, {31'd0, i[1]});
            checkOutput($sformatf("vec%0d ResultSrcM", i), {31'd0, ResultSrcM}, {31'd0, i[2]});
            checkOutput($sformatf("vec%0d RD_M", i), {27'd0, RD_M}, 32'(i + 1));
            checkOutput($sformatf("vec%0d PCPlus4M", i), PCPlus4M, 32'h1000 + 32'(i * 4));
        end

        // Forward from M: first produce 0x10, then A=ALU_ResultM, B=ResultW.
        ResultW  = 32'h20;
        PCPlus4E = 32'h5004;
        setAdd(32'd8, 32'd8, 5'd5);
        tick();
        checkOutput("fwd setup ALU_ResultM", ALU_ResultM, 32'h10);
        setAdd(32'h777, 32'h777, 5'd9);
        ForwardA_E = 2'b10;
        ForwardB_E = 2'b01;
        MemWriteE  = 1'b1;
        tick();
        checkOutput("fwd ALU_ResultM", ALU_ResultM, 32'h30);
        checkOutput("fwd WriteDataM", WriteDataM, 32'h20);
        checkOutput("fwd RD_M", {27'd0, RD_M}, 32'd9);

        // Hold for three cycles; forwarding from M sees the held 0x30.
        EnM = 1'b0;
        for (int k = 0; k < 3; k++) begin
            setAdd(32'(k + 100), 32'h30, 5'(k + 20));
            ALUControlE = 3'b001;
            BranchE     = 1'b1;
            ForwardA_E  = 2'b10;
            PCPlus4E    = 32'h9000 + 32'(k);
            #1;
            checkOutput($sformatf("hold%0d PCSrcE", k), {31'd0, PCSrcE}, 32'd1);
            tick();
            checkOutput($sformatf("hold%0d ALU_ResultM", k), ALU_ResultM, 32'h30);
            checkOutput($sformatf("hold%0d WriteDataM", k), WriteDataM, 32'h20);
            checkOutput($sformatf("hold%0d RD_M", k), {27'd0, RD_M}, 32'd9);
            checkOutput($sformatf("hold%0d MemWriteM", k), {31'd0, MemWriteM}, 32'd1);
            checkOutput($sformatf("hold%0d PCPlus4M", k), PCPlus4M, 32'h5004);
        end

        // Clear with enable also set: bubble wins.
        EnM  = 1'b1;
        ClrM = 1'b1;
        setAdd(32'd1, 32'd1, 5'd7);
        MemWriteE  = 1'b1;
        ResultSrcE = 1'b1;
        tick();
        checkAllZero("clr+en");

        // Clear while disabled also empties the register.
        ClrM = 1'b0;
        tick();
        checkOutput("reload ALU_ResultM", ALU_ResultM, 32'd2);
        EnM  = 1'b0;
        ClrM = 1'b1;
        tick();
        checkAllZero("clr-noen");
        ClrM = 1'b0;
        EnM  = 1'b1;

        // Asynchronous reset mid-cycle discards in-flight contents immediately.
        setAdd(32'd40, 32'd2, 5'd11);
        tick();
        checkOutput("pre-rst ALU_ResultM", ALU_ResultM, 32'd42);
        #2;
        rst = 1'b1;
        #1;
        checkAllZero("async rst");
        tick();
        rst = 1'b0;
        tick();
        checkOutput("post-rst ALU_ResultM", ALU_ResultM, 32'd42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
